// File: rtl/systolic_gemm_pkg.sv
// -----------------------------------------------------------------------------
// systolic_gemm_pkg
// Shared definitions for the systolic GEMM array: the controller state type
// and the default geometry / width constants used by systolic_gemm.
// -----------------------------------------------------------------------------
package systolic_gemm_pkg;

    localparam int SA_ROWS = 8;   // array rows (M dimension of a tile)
    localparam int SA_COLS = 8;   // array columns (N dimension of a tile)
    localparam int SA_DW   = 16;  // signed operand width
    localparam int SA_AW   = 32;  // signed accumulator width (>= 2*DW)
    localparam int SA_KW   = 16;  // width of the K-length counter

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2,
        DRAIN  = 2'd3
    } sa_state_t;

endpackage

// File: rtl/sa_skew.sv
// -----------------------------------------------------------------------------
// sa_skew
// Fixed-depth delay line for one operand lane plus its valid token. DEPTH=0
// is a plain passthrough. A synchronous clear empties the line so that a new
// tile never sees operands from an earlier one.
//
// Ports
//   clk, rst   : clock, asynchronous active-low reset
//   clear      : synchronous flush of all stages
//   d_in, v_in : lane data and valid token entering the line
//   d_out,v_out: same, DEPTH cycles later
// -----------------------------------------------------------------------------
module sa_skew #(
    parameter int DW    = 16,
    parameter int DEPTH = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic [DW-1:0] d_in,
    input  logic          v_in,
    output logic [DW-1:0] d_out,
    output logic          v_out
);

    generate
        if (DEPTH == 0) begin : g_pass
            // Row/column 0 is not delayed; the control inputs are intentionally idle.
            logic unused_ctrl_s;
            assign unused_ctrl_s = ^{clk, rst, clear};
            assign d_out = d_in;
            assign v_out = v_in;
        end else begin : g_line
            logic [DW-1:0] d_q [DEPTH];
            logic [DW-1:0] d_d [DEPTH];
            logic          v_q [DEPTH];
            logic          v_d [DEPTH];

            // Next-stage values: shift by one, or empty the line on clear.
            always_comb begin
                if (clear) begin
                    d_d[0] = {DW{1'b0}};
                    v_d[0] = 1'b0;
                end else begin
                    d_d[0] = d_in;
                    v_d[0] = v_in;
                end
                for (int k = 1; k < DEPTH; k++) begin
                    if (clear) begin
                        d_d[k] = {DW{1'b0}};
                        v_d[k] = 1'b0;
                    end else begin
                        d_d[k] = d_q[k-1];
                        v_d[k] = v_q[k-1];
                    end
                end
            end

            // Delay-line stage registers.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        d_q[k] <= {DW{1'b0}};
                        v_q[k] <= 1'b0;
                    end
                end else begin
                    for (int k = 0; k < DEPTH; k++) begin
                        d_q[k] <= d_d[k];
                        v_q[k] <= v_d[k];
                    end
                end
            end

            assign d_out = d_q[DEPTH-1];
            assign v_out = v_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/systolic_gemm.sv
// -----------------------------------------------------------------------------
// systolic_gemm
// Output-stationary ROWS x COLS systolic array computing C = A * B for one
// tile. Each K beat delivers one column of A (a_col) and one row of B (b_row).
// Row i / column j operands are skewed by i / j cycles, then march right (A)
// and down (B) one cell per cycle with a valid token; cell (i,j) accumulates
// a*b only when both tokens are valid. After the last beat the array is
// flushed for ROWS+COLS-1 cycles and the result rows are drained in order.
//
// Build option
//   SYSTOLIC_GEMM_SATURATE_EN : accumulators clamp to the signed AW range
//                               instead of wrapping.
//
// Ports
//   clk, rst             : clock, asynchronous active-low reset
//   start, k_len         : begin a tile of k_len beats (honoured in IDLE only)
//   in_valid/in_ready    : operand beat handshake (a_col, b_row)
//   out_valid/out_ready  : result row handshake (out_row = C[out_idx][*])
//   busy                 : controller not idle
//   done                 : one-cycle pulse after the last row is taken
// Requires ROWS >= 2.
// -----------------------------------------------------------------------------
module systolic_gemm
    import systolic_gemm_pkg::*;
#(
    parameter int ROWS = SA_ROWS,
    parameter int COLS = SA_COLS,
    parameter int DW   = SA_DW,
    parameter int AW   = SA_AW,
    parameter int KW   = SA_KW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [KW-1:0]            k_len,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ROWS*DW-1:0]       a_col,
    input  logic [COLS*DW-1:0]       b_row,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [COLS*AW-1:0]       out_row,
    output logic [$clog2(ROWS)-1:0]  out_idx,
    output logic                     busy,
    output logic                     done
);

    localparam int IW = $clog2(ROWS);
    localparam int FW = $clog2(ROWS + COLS) + 1;

    // Accumulate one product into an accumulator, wrapping or clamping.
    function automatic logic signed [AW-1:0] mac_add(
        input logic signed [AW-1:0] acc,
        input logic signed [AW-1:0] prod
    );
`ifdef SYSTOLIC_GEMM_SATURATE_EN
        logic signed [AW:0] sum;
        sum = {acc[AW-1], acc} + {prod[AW-1], prod};
        if (sum[AW] != sum[AW-1]) begin
            mac_add = sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
        end else begin
            mac_add = sum[AW-1:0];
        end
`else
        mac_add = acc + prod;
`endif
    endfunction

    sa_state_t         state_q, state_d;
    logic [KW-1:0]     k_len_q, k_len_d;
    logic [KW-1:0]     beat_q, beat_d;
    logic [FW-1:0]     flush_q, flush_d;
    logic [IW-1:0]     out_idx_q, out_idx_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [COLS*AW-1:0] out_row_q, out_row_d;

    logic              clear_s;
    logic              beat_acc_s;
    logic [IW-1:0]     next_idx_s;
    logic [COLS*AW-1:0] row_mux_s;

    // Operand pipelines: column COLS / row ROWS are the array's exits.
    logic [DW-1:0]        a_pipe [ROWS][COLS+1];
    logic                 a_vld  [ROWS][COLS+1];
    logic [DW-1:0]        b_pipe [ROWS+1][COLS];
    logic                 b_vld  [ROWS+1][COLS];
    logic signed [AW-1:0] acc_w  [ROWS][COLS];

    // in_ready_q is high exactly in STREAM, so beats elsewhere are dropped.
    assign beat_acc_s = in_valid && in_ready_q;

    // Row loaded into out_row next: row 0 when entering DRAIN, else the following row.
    assign next_idx_s = (state_q == DRAIN) ? (out_idx_q + IW'(1)) : {IW{1'b0}};

    // Select the accumulator row addressed by next_idx_s.
    always_comb begin
        row_mux_s = {(COLS*AW){1'b0}};
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                row_mux_s[c*AW +: AW] = row_mux_s[c*AW +: AW]
                    | ((IW'(r) == next_idx_s) ? acc_w[r][c] : {AW{1'b0}});
            end
        end
    end

    // Controller next-state and registered-output decode.
    always_comb begin
        state_d   = state_q;
        k_len_d   = k_len_q;
        beat_d    = beat_q;
        flush_d   = flush_q;
        out_idx_d = out_idx_q;
        out_row_d = out_row_q;
        done_d    = 1'b0;
        clear_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    clear_s   = 1'b1;
                    k_len_d   = k_len;
                    beat_d    = {KW{1'b0}};
                    flush_d   = {FW{1'b0}};
                    out_idx_d = {IW{1'b0}};
                    // Accumulators are being cleared, so a zero-length tile drains zeros.
                    out_row_d = {(COLS*AW){1'b0}};
                    if (k_len == {KW{1'b0}}) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = STREAM;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            STREAM: begin
                if (beat_acc_s) begin
                    beat_d = beat_q + KW'(1);
                    if (beat_q == k_len_q - KW'(1)) begin
                        state_d = FLUSH;
                        flush_d = {FW{1'b0}};
                    end else begin
                        state_d = STREAM;
                    end
                end else begin
                    state_d = STREAM;
                end
            end
            FLUSH: begin
                // Last beat needs ROWS+COLS-2 more cycles to reach the far cell.
                if (flush_q == FW'(ROWS + COLS - 2)) begin
                    state_d   = DRAIN;
                    out_idx_d = {IW{1'b0}};
                    out_row_d = row_mux_s;
                end else begin
                    flush_d = flush_q + FW'(1);
                end
            end
            DRAIN: begin
                if (out_valid_q && out_ready) begin
                    if (out_idx_q == IW'(ROWS - 1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        out_idx_d = next_idx_s;
                        out_row_d = row_mux_s;
                    end
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        in_ready_d  = (state_d == STREAM);
        out_valid_d = (state_d == DRAIN);
        busy_d      = (state_d != IDLE);
    end

    // Controller state and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            k_len_q     <= {KW{1'b0}};
            beat_q      <= {KW{1'b0}};
            flush_q     <= {FW{1'b0}};
            out_idx_q   <= {IW{1'b0}};
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_row_q   <= {(COLS*AW){1'b0}};
        end else begin
            state_q     <= state_d;
            k_len_q     <= k_len_d;
            beat_q      <= beat_d;
            flush_q     <= flush_d;
            out_idx_q   <= out_idx_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            out_row_q   <= out_row_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_row   = out_row_q;
    assign out_idx   = out_idx_q;
    assign busy      = busy_q;
    assign done      = done_q;

    genvar gi, gj;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_row_skew
            sa_skew #(.DW(DW), .DEPTH(gi)) u_skew (
                .clk   (clk),
                .rst   (rst),
                .clear (clear_s),
                .d_in  (a_col[gi*DW +: DW]),
                .v_in  (beat_acc_s),
                .d_out (a_pipe[gi][0]),
                .v_out (a_vld[gi][0])
            );
            logic unused_a_exit_s;
            assign unused_a_exit_s = ^{a_pipe[gi][COLS], a_vld[gi][COLS]};
        end

        for (gj = 0; gj < COLS; gj++) begin : g_col_skew
            sa_skew #(.DW(DW), .DEPTH(gj)) u_skew (
                .clk   (clk),
                .rst   (rst),
                .clear (clear_s),
                .d_in  (b_row[gj*DW +: DW]),
                .v_in  (beat_acc_s),
                .d_out (b_pipe[0][gj]),
                .v_out (b_vld[0][gj])
            );
            logic unused_b_exit_s;
            assign unused_b_exit_s = ^{b_pipe[ROWS][gj], b_vld[ROWS][gj]};
        end

        for (gi = 0; gi < ROWS; gi++) begin : g_mac_row
            for (gj = 0; gj < COLS; gj++) begin : g_mac_col
                logic [DW-1:0]          a_q, a_d, b_q, b_d;
                logic                   av_q, av_d, bv_q, bv_d;
                logic signed [AW-1:0]   acc_q, acc_d;
                logic signed [2*DW-1:0] a_ext_s, b_ext_s, prod_s;

                assign a_ext_s = {{DW{a_pipe[gi][gj][DW-1]}}, a_pipe[gi][gj]};
                assign b_ext_s = {{DW{b_pipe[gi][gj][DW-1]}}, b_pipe[gi][gj]};
                assign prod_s  = a_ext_s * b_ext_s;

                // Cell next state: forward operands, accumulate on valid tokens.
                always_comb begin
                    if (clear_s) begin
                        a_d   = {DW{1'b0}};
                        b_d   = {DW{1'b0}};
                        av_d  = 1'b0;
                        bv_d  = 1'b0;
                        acc_d = {AW{1'b0}};
                    end else begin
                        a_d  = a_pipe[gi][gj];
                        b_d  = b_pipe[gi][gj];
                        av_d = a_vld[gi][gj];
                        bv_d = b_vld[gi][gj];
                        if (a_vld[gi][gj] && b_vld[gi][gj]) begin
                            acc_d = mac_add(acc_q, AW'(prod_s));
                        end else begin
                            acc_d = acc_q;
                        end
                    end
                end

                // Cell operand and accumulator registers.
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        a_q   <= {DW{1'b0}};
                        b_q   <= {DW{1'b0}};
                        av_q  <= 1'b0;
                        bv_q  <= 1'b0;
                        acc_q <= {AW{1'b0}};
                    end else begin
                        a_q   <= a_d;
                        b_q   <= b_d;
                        av_q  <= av_d;
                        bv_q  <= bv_d;
                        acc_q <= acc_d;
                    end
                end

                assign a_pipe[gi][gj+1] = a_q;
                assign a_vld[gi][gj+1]  = av_q;
                assign b_pipe[gi+1][gj] = b_q;
                assign b_vld[gi+1][gj]  = bv_q;
                assign acc_w[gi][gj]    = acc_q;
            end
        end
    endgenerate

endmodule

// File: tb/tb_systolic_gemm.sv
module tb_systolic_gemm;

    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int DW   = 16;
    localparam int AW   = 32;
    localparam int KW   = 16;
    localparam int KMAX = 8;

    logic                 clk       = 1'b0;
    logic                 rst       = 1'b0;
    logic                 start     = 1'b0;
    logic [KW-1:0]        k_len     = '0;
    logic                 in_valid  = 1'b0;
    logic                 out_ready = 1'b0;
    logic [ROWS*DW-1:0]   a_col     = '0;
    logic [COLS*DW-1:0]   b_row     = '0;
    logic                 in_ready;
    logic                 out_valid;
    logic [COLS*AW-1:0]   out_row;
    logic [$clog2(ROWS)-1:0] out_idx;
    logic                 busy;
    logic                 done;

    always #5 clk = ~clk;

    systolic_gemm #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .AW(AW), .KW(KW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .k_len     (k_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_col     (a_col),
        .b_row     (b_row),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_idx   (out_idx),
        .busy      (busy),
        .done      (done)
    );

    int errors = 0;
    int checks = 0;
    int exp_idx = 0;
    int done_cnt = 0;
    int stream_cycles = 0;
    longint model_c [ROWS][COLS];
    longint a_mat [ROWS][KMAX];
    longint b_mat [KMAX][COLS];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference accumulation: plain integer sum, then wrap or clamp to AW bits.
    function automatic longint acc_op(input longint acc, input longint p);
        longint s;
        s = acc + p;
`ifdef SYSTOLIC_GEMM_SATURATE_EN
        if (s > 64'sd2147483647) s = 64'sd2147483647;
        else if (s < -64'sd2147483648) s = -64'sd2147483648;
`else
        s = longint'(int'(s));
`endif
        return s;
    endfunction

    task automatic model_beat(input int k);
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++)
                model_c[i][j] = acc_op(model_c[i][j], a_mat[i][k] * b_mat[k][j]);
    endtask

    // Compare every drained row against the model, in bench-tracked order.
    always @(negedge clk) begin
        if (rst && out_valid) begin
            check("drain_idx", longint'(out_idx), longint'(exp_idx));
            for (int j = 0; j < COLS; j++)
                check("c_elem", longint'($signed(out_row[j*AW +: AW])), model_c[exp_idx][j]);
            if (out_ready) exp_idx = (exp_idx + 1) % ROWS;
        end
    end

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (in_ready) stream_cycles++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_tile(input int k);
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++)
                model_c[i][j] = 0;
        exp_idx = 0;
        start = 1'b1;
        k_len = KW'(k);
        step();
        start = 1'b0;
    endtask

    task automatic feed(input int nbeats, input bit bubbles);
        int sent;
        int cyc;
        sent = 0;
        cyc = 0;
        while (sent < nbeats && cyc < 200) begin
            if (bubbles && (cyc % 3 == 2)) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                for (int i = 0; i < ROWS; i++) a_col[i*DW +: DW] = DW'(a_mat[i][sent]);
                for (int j = 0; j < COLS; j++) b_row[j*DW +: DW] = DW'(b_mat[sent][j]);
            end
            if (in_valid && in_ready) begin
                model_beat(sent);
                sent++;
            end
            step();
            cyc++;
        end
        in_valid = 1'b0;
        check("feed_beats", longint'(sent), longint'(nbeats));
    endtask

    task automatic wait_drain(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            step();
            lat++;
        end
        check("drain_reached", longint'(out_valid), 64'd1);
    endtask

    task automatic drain(input int stall_row, input int stall_len);
        int hs;
        int cyc;
        int left;
        int d0;
        logic [COLS*AW-1:0] held;
        hs = 0;
        cyc = 0;
        left = stall_len;
        d0 = done_cnt;
        held = '0;
        while (hs < ROWS && cyc < 200) begin
            if (hs == stall_row && left > 0) begin
                out_ready = 1'b0;
                check("stall_idx", longint'(out_idx), longint'(stall_row));
                if (left == stall_len) held = out_row;
                else check("stall_row_stable", longint'(out_row == held), 64'd1);
                left--;
            end else begin
                out_ready = 1'b1;
                if (out_valid) hs++;
            end
            step();
            cyc++;
        end
        out_ready = 1'b0;
        check("handshakes", longint'(hs), longint'(ROWS));
        check("done_pulse", longint'(done), 64'd1);
        check("busy_after", longint'(busy), 64'd0);
        step();
        check("done_once", longint'(done_cnt - d0), 64'd1);
        check("done_low", longint'(done), 64'd0);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_in_ready"}, longint'(in_ready), 64'd0);
        check({tag, "_out_valid"}, longint'(out_valid), 64'd0);
        check({tag, "_busy"}, longint'(busy), 64'd0);
        check({tag, "_done"}, longint'(done), 64'd0);
        check({tag, "_out_idx"}, longint'(out_idx), 64'd0);
        check({tag, "_out_row"}, longint'(out_row == '0), 64'd1);
    endtask

    initial begin
        int lat;
        int d0;
        int s0;

        repeat (3) @(posedge clk);
        #1;
        check_idle_zero("reset");
        rst = 1'b1;
        step();

        // All a=2, b=3, one beat.
        for (int i = 0; i < ROWS; i++) for (int k = 0; k < KMAX; k++) a_mat[i][k] = 2;
        for (int k = 0; k < KMAX; k++) for (int j = 0; j < COLS; j++) b_mat[k][j] = 3;
        start_tile(1);
        feed(1, 1'b0);
        wait_drain(lat);
        check("flush_latency", longint'(lat), longint'(ROWS + COLS - 1));
        check("model_t1_00", model_c[0][0], 64'sd6);
        check("model_t1_77", model_c[7][7], 64'sd6);
        drain(-1, 0);

        // A = identity, B[k][j] = 8k+j, with bubbles.
        for (int i = 0; i < ROWS; i++) for (int k = 0; k < KMAX; k++) a_mat[i][k] = (i == k) ? 1 : 0;
        for (int k = 0; k < KMAX; k++) for (int j = 0; j < COLS; j++) b_mat[k][j] = 8 * k + j;
        start_tile(8);
        feed(8, 1'b1);
        wait_drain(lat);
        check("model_t2_53", model_c[5][3], 64'sd43);
        check("model_t2_70", model_c[7][0], 64'sd56);
        drain(-1, 0);

        // Signed mix, consumer stalls five cycles on row 3.
        for (int i = 0; i < ROWS; i++) for (int k = 0; k < KMAX; k++) a_mat[i][k] = i - k;
        for (int k = 0; k < KMAX; k++) for (int j = 0; j < COLS; j++) b_mat[k][j] = j * k - 3;
        start_tile(3);
        feed(3, 1'b0);
        wait_drain(lat);
        check("model_t3_00", model_c[0][0], 64'sd9);
        check("model_t3_21", model_c[2][1], -64'sd8);
        drain(3, 5);

        // Overflow: a = b = 32767 over four beats.
        for (int i = 0; i < ROWS; i++) for (int k = 0; k < KMAX; k++) a_mat[i][k] = 32767;
        for (int k = 0; k < KMAX; k++) for (int j = 0; j < COLS; j++) b_mat[k][j] = 32767;
        start_tile(4);
        feed(4, 1'b0);
        wait_drain(lat);
`ifdef SYSTOLIC_GEMM_SATURATE_EN
        check("model_t4_sat", model_c[6][2], 64'sd2147483647);
`else
        check("model_t4_wrap", model_c[6][2], -64'sd262140);
`endif
        drain(-1, 0);

        // Reset at beat 3 of 8 aborts the tile.
        start_tile(8);
        feed(3, 1'b0);
        d0 = done_cnt;
        rst = 1'b0;
        #1;
        check_idle_zero("midreset");
        step();
        step();
        rst = 1'b1;
        step();
        check("no_done_after_abort", longint'(done_cnt - d0), 64'd0);
        for (int i = 0; i < ROWS; i++) for (int k = 0; k < KMAX; k++) a_mat[i][k] = 1;
        for (int k = 0; k < KMAX; k++) for (int j = 0; j < COLS; j++) b_mat[k][j] = 1;
        start_tile(1);
        feed(1, 1'b0);
        wait_drain(lat);
        check("model_t5_44", model_c[4][4], 64'sd1);
        drain(-1, 0);

        // Start pulsed during FLUSH is ignored.
        for (int i = 0; i < ROWS; i++) for (int k = 0; k < KMAX; k++) a_mat[i][k] = i + 1;
        for (int k = 0; k < KMAX; k++) for (int j = 0; j < COLS; j++) b_mat[k][j] = j - 3;
        start_tile(1);
        feed(1, 1'b0);
        step();
        step();
        start = 1'b1;
        k_len = KW'(5);
        step();
        start = 1'b0;
        check("flush_no_stream", longint'(in_ready), 64'd0);
        wait_drain(lat);
        check("flush_ignores_start", longint'(lat + 3), longint'(ROWS + COLS - 1));
        check("model_t6_25", model_c[2][5], 64'sd6);
        drain(-1, 0);

        // k_len = 0 drains zero rows straight away.
        s0 = stream_cycles;
        start_tile(0);
        wait_drain(lat);
        check("k0_latency", longint'(lat), 64'd0);
        drain(-1, 0);
        check("k0_no_stream", longint'(stream_cycles - s0), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
